// File: rtl/int_gen_pkg.sv
// int_gen_pkg: shared state encoding, register offsets and CTRL field layout for int_gen_dev
package int_gen_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_PENDING = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] OFF_ACK    = 4'h0;
    localparam logic [3:0] OFF_TARGET = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hc;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_DLY_LSB = 8;
    localparam int CTRL_DLY_W = 8;
    localparam int CTRL_REP_LSB = 16;
    localparam int CTRL_REP_W = 4;
endpackage

// File: rtl/int_gen_regs.sv
// int_gen_regs: bus decode, TARGET/CTRL storage and combinational read mux
// Ports: clk, reset (sync, active-high); m_int_addr/m_int_byteen/m_int_wdata bus write,
// status (STATUS word from the FSM), m_int_rdata read data; target, ctrl_en, ctrl_delay
// register fields; ack_pulse (ACK write strobe), ctrl_wr (full-word CTRL write strobe).
// Macro INT_GEN_REARM_EN: when undefined the CTRL repeat field reads back as 0.
module int_gen_regs
    import int_gen_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_7f20,
    parameter logic [31:0] DEFAULT_TARGET = 32'h0000_301c,
    parameter int          DELAY_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        m_int_addr,
    input  logic [3:0]         m_int_byteen,
    input  logic [31:0]        m_int_wdata,
    input  logic [31:0]        status,
    output logic [31:0]        m_int_rdata,
    output logic [31:0]        target,
    output logic               ctrl_en,
    output logic [DELAY_W-1:0] ctrl_delay,
    output logic               ack_pulse,
    output logic               ctrl_wr
);
    logic [31:0] ctrl;
    logic [31:0] ctrl_rd;
    logic [31:0] rel;
    logic [3:0]  off;
    logic        in_win;
    logic        full;
    logic        target_wr;

    assign rel       = (m_int_addr & ~32'h3) - BASE_ADDR;
    assign in_win    = rel < 32'h10;
    assign off       = rel[3:0];
    assign full      = m_int_byteen == 4'hf;
    assign ack_pulse = in_win && off == OFF_ACK && |m_int_byteen;
    assign target_wr = in_win && off == OFF_TARGET && full;
    assign ctrl_wr   = in_win && off == OFF_CTRL && full;

    assign ctrl_en    = ctrl[CTRL_EN_BIT];
    assign ctrl_delay = ctrl[CTRL_DLY_LSB +: DELAY_W];
`ifdef INT_GEN_REARM_EN
    assign ctrl_rd = ctrl;
`else
    assign ctrl_rd = ctrl & ~(32'((1 << CTRL_REP_W) - 1) << CTRL_REP_LSB);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            target <= DEFAULT_TARGET;
            ctrl   <= '0;
        end else begin
            if (target_wr) target <= m_int_wdata;
            if (ctrl_wr) ctrl <= m_int_wdata;
        end
    end

    always_comb begin
        m_int_rdata = '0;
        if (in_win)
            m_int_rdata = off == OFF_TARGET ? target :
                          off == OFF_CTRL   ? ctrl_rd :
                          off == OFF_STATUS ? status : '0;
    end
endmodule

// File: rtl/int_gen_dev.sv
// int_gen_dev: interrupt source that fires when the committed PC hits a programmed target
// Ports: clk, reset (sync, active-high); macroscopic_pc committed PC; m_int_addr/m_int_byteen/
// m_int_wdata device bus write, m_int_rdata combinational read data; interrupt registered IRQ.
// Macro INT_GEN_REARM_EN: re-arm after each ACK until the CTRL repeat count is used up;
// undefined gives a strictly one-shot generator.
module int_gen_dev
    import int_gen_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_7f20,
    parameter logic [31:0] DEFAULT_TARGET = 32'h0000_301c,
    parameter int          DELAY_W        = 8,
    parameter int          CNT_W          = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] macroscopic_pc,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    input  logic [31:0] m_int_wdata,
    output logic [31:0] m_int_rdata,
    output logic        interrupt
);
    state_t             state, state_next;
    logic [DELAY_W-1:0] dly_cnt;
    logic [CNT_W-1:0]   rep_cnt;
    logic [31:0]        target;
    logic [31:0]        status;
    logic [DELAY_W-1:0] ctrl_delay;
    logic               ctrl_en;
    logic               ack_pulse;
    logic               ctrl_wr;
    logic               match;
    logic               rearm;
    logic               irq_next;

    int_gen_regs #(
        .BASE_ADDR      (BASE_ADDR),
        .DEFAULT_TARGET (DEFAULT_TARGET),
        .DELAY_W        (DELAY_W)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .m_int_addr   (m_int_addr),
        .m_int_byteen (m_int_byteen),
        .m_int_wdata  (m_int_wdata),
        .status       (status),
        .m_int_rdata  (m_int_rdata),
        .target       (target),
        .ctrl_en      (ctrl_en),
        .ctrl_delay   (ctrl_delay),
        .ack_pulse    (ack_pulse),
        .ctrl_wr      (ctrl_wr)
    );

    assign match = (macroscopic_pc & ~32'h3) == target;
`ifdef INT_GEN_REARM_EN
    assign rearm = rep_cnt > CNT_W'(1);
`else
    assign rearm = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            dly_cnt   <= '0;
            interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            interrupt <= irq_next;
            if (state == S_ARMED && match && !ctrl_wr) dly_cnt <= ctrl_delay;
            else if (state == S_DELAY) dly_cnt <= dly_cnt - 1'b1;
        end
    end

`ifdef INT_GEN_REARM_EN
    // Repeat field 0 is treated as a single shot.
    always_ff @(posedge clk) begin
        if (reset) rep_cnt <= '0;
        else if (ctrl_wr) rep_cnt <= m_int_wdata[CTRL_REP_LSB +: CNT_W] == '0 ? CNT_W'(1) : m_int_wdata[CTRL_REP_LSB +: CNT_W];
        else if (state == S_PENDING && ack_pulse) rep_cnt <= rep_cnt - 1'b1;
    end
`else
    assign rep_cnt = '0;
`endif

    always_comb begin
        state_next = state;
        if (ctrl_wr) state_next = m_int_wdata[CTRL_EN_BIT] ? S_ARMED : S_IDLE;
        else
            case (state)
                S_IDLE:    state_next = ctrl_en ? S_ARMED : S_IDLE;
                S_ARMED:   state_next = !match ? S_ARMED : ctrl_delay == '0 ? S_PENDING : S_DELAY;
                S_DELAY:   state_next = dly_cnt == DELAY_W'(1) ? S_PENDING : S_DELAY;
                S_PENDING: state_next = !ack_pulse ? S_PENDING : rearm ? S_ARMED : S_DONE;
                S_DONE:    state_next = S_DONE;
                default:   state_next = S_IDLE;
            endcase
    end

    // The IRQ register follows PENDING one edge late, but drops on the same edge that leaves it.
    always_comb begin
        irq_next = state == S_PENDING && state_next == S_PENDING;
        status = '0;
        status[2:0] = state;
        status[3] = interrupt;
        status[CTRL_DLY_LSB +: DELAY_W] = dly_cnt;
        status[CTRL_REP_LSB +: CNT_W] = rep_cnt;
    end
endmodule
